serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial adder built downstream of the half-adder cell; consumes HA sum/carry per bit.
//   Latches two WIDTH-bit operands on start and adds them LSB-first, one bit per clock.
//   The carry is held in a flip-flop between bits.
//   Presents the WIDTH-bit sum plus carry-out with a one-cycle done pulse.
//   Trades latency for area in the datapath: one full-adder cell instead of WIDTH.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 2..32
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      reset: one clock; reset is asynchronous and active-high
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  operand A, captured on accepted start
//   b       in   WIDTH  operand B, captured on accepted start
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse when the result becomes valid
//   sum     out  WIDTH  result; holds until the next accepted start
//   cout    out  1      final carry out of the MSB; held like sum
// BEHAVIOUR
//   Reset values: busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, state=IDLE.
//   States:
//     IDLE -start-> RUN
//     RUN -(counter==WIDTH-1)-> DONE
//     DONE -> IDLE; DONE -start-> RUN directly
//   Accept, on the edge where start=1 in IDLE/DONE:
//     shreg_a<=a, shreg_b<=b, carry<=0, cnt<=0, state<=RUN.
//     sum and cout keep their old values until the last bit lands.
//   RUN, per edge:
//     s,c = FA(shreg_a[0], shreg_b[0], carry).
//     Result shift register shifts right with s entering at the MSB.
//     carry<=c; shreg_a, shreg_b shift right; cnt++.
//   Last RUN edge (cnt==WIDTH-1):
//     sum <= completed shift register.
//     cout <= c.
//     state <= DONE.
//   Latency: start accepted at edge k; sum/cout valid and done=1 after edge k+WIDTH; done lasts exactly one cycle.
//   Arithmetic: {cout,sum} == a+b (unsigned, WIDTH+1 bits); no truncation except into the cout bit.
//   Boundaries:
//     start while busy is ignored; operands are not re-sampled.
//     start asserted during done=1 cycle: accepted, back-to-back op, busy=1 next cycle.
//     start held high continuously: a new operation every WIDTH+1 cycles.
//     a=b=all-ones: sum=all-ones-minus-1 ({1..10}), cout=1.
//     rst asserted mid-RUN: immediate return to reset values; partial result discarded, no done pulse.
//     Counter never exceeds WIDTH-1; cnt width = $clog2(WIDTH).
// CONFIGURATION
//   Macro SERIAL_ADDER_OVF_EN.
//     Defined: adds output port ovf (out, 1).
//       Two's-complement overflow = carry into MSB XOR carry out of MSB.
//       Captured on the last RUN edge; reset 0; held with sum.
//     Undefined: no ovf port, no extra flop; behaviour otherwise identical.
// STRUCTURE
//   Package serial_adder_pkg:
//     state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
//     WIDTH legal-range constants (MIN 2, MAX 32).
//   Sub-module fa_bit:
//     one-bit full adder = two half-adder cells plus OR of their carries.
//     Ports a, b, ci, s, co; purely combinational.
//     Instantiated once.
//   serial_adder holds the FSM, counter, operand/result shift registers and carry flop.
// TESTING
//   1. WIDTH=8, a=8'h05, b=8'h03, start 1 cycle.
//      -> busy high 8 cycles; done pulse after edge k+8; sum=8'h08, cout=0.
//   2. a=8'hFF, b=8'h01.
//      -> sum=8'h00, cout=1.
//      a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
//      With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> ovf=1; 8'hFF+8'h01 -> ovf=0.
//   3. Hold start=1 with a=8'h10, b=8'h20, then change operands to a=8'h01, b=8'h01 while busy.
//      -> first result 8'h30, second 8'h02; done pulses every 9 cycles; no mid-RUN capture.
//   4. Assert rst at cnt=4 of an operation.
//      -> all outputs 0 on the same cycle; no done; next start produces a correct result.
//   5. Random a,b over 1000 ops at WIDTH=8 and WIDTH=16.
//      -> {cout,sum} == a+b every time; done exactly one cycle per accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
// This package holds the FSM state encoding and the legal WIDTH range.
package serial_adder_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Legal operand width range
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    // Returns 1 when a WIDTH value lies inside the supported range.
    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: one-bit full adder built from two half-adder cells.
// The carry out is the OR of the two half-adder carries.
// The module is purely combinational.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: a + b
    assign w_s1 = a ^ b;
    assign w_c1 = a & b;

    // Second half adder: partial sum + carry in
    assign s    = w_s1 ^ ci;
    assign w_c2 = w_s1 & ci;

    // The two half-adder carries can never both be 1
    assign co   = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder that adds two WIDTH-bit operands LSB-first.
// It processes one bit per clock through a single full-adder cell and holds the carry in a flop.
// Optional macro SERIAL_ADDER_OVF_EN adds the ovf output, which reports two's-complement overflow.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;
    logic             w_last;

    // The single full-adder cell consumes the current LSBs and the held carry
    fa_bit u_fa (
        .a  (r_sh_a[0]),
        .b  (r_sh_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_cnt == CNT_LAST);

    // FSM, datapath shift registers, carry flop and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        // Capture operands; sum/cout keep the previous result until the last bit
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_next;
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_carry <= w_c;
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // The held carry is the carry into the MSB and w_c is the carry out of it
                        r_ovf   <= r_carry ^ w_c;
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder at WIDTH=8 and WIDTH=16.
// Expected results come from plain integer addition of the applied operands.
module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [31:0] a, b;
    logic        busy8, done8, cout8, busy16, done16, cout16;
    logic [7:0]  sum8;
    logic [15:0] sum16;
`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf16;
`endif
    logic        sel;   // 0: 8-bit DUT, 1: 16-bit DUT

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf8),
`endif
        .cout(cout8));

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .sum(sum16),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf16),
`endif
        .cout(cout16));

    wire        c_busy = sel ? busy16 : busy8;
    wire        c_done = sel ? done16 : done8;
    wire [31:0] c_sum  = sel ? {16'b0, sum16} : {24'b0, sum8};
    wire        c_cout = sel ? cout16 : cout8;
`ifdef SERIAL_ADDER_OVF_EN
    wire        c_ovf  = sel ? ovf16 : ovf8;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start16 = v; else start8 = v;
    endtask

    // Reference model: unsigned add of W-bit operands, with cout and signed overflow
    task automatic model(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] es, output logic ec, output logic eo);
        int   w;
        logic [32:0] full;
        logic [31:0] mask;
        logic sx, sy, ss;
        w    = sel ? 16 : 8;
        mask = (32'd1 << w) - 32'd1;
        full = {1'b0, x & mask} + {1'b0, y & mask};
        es   = full[31:0] & mask;
        ec   = full[w];
        sx   = x[w-1];
        sy   = y[w-1];
        ss   = es[w-1];
        eo   = (sx == sy) && (ss != sx);
    endtask

    // Counts negedges until done is seen (bounded) and how many of them had busy=1
    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0; nbusy = 0;
        while (!c_done && cyc < 60) begin
            if (c_busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (!c_done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] es; logic ec, eo;
        model(x, y, es, ec, eo);
        chk({tag, "_sum"}, c_sum, es);
        chk({tag, "_cout"}, c_cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, c_ovf, eo);
`endif
    endtask

    // One complete operation with a single-cycle start pulse
    task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y, input bit full);
        int cyc, nb, w;
        w = sel ? 16 : 8;
        @(negedge clk);
        a = x; b = y; set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        wait_done(cyc, nb);
        if (full) begin
            chk({tag, "_lat"}, cyc, w);
            chk({tag, "_busy_cycles"}, nb, w);
            chk({tag, "_busy_at_done"}, c_busy, 0);
        end
        check_result(tag, x, y);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, c_done, 0);
    endtask

    initial begin
        int cyc, nb;
        rst = 1'b1; start8 = 0; start16 = 0; a = 0; b = 0; sel = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", busy8, 0);  chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);    chk("rst_cout8", cout8, 0);
        chk("rst_sum16", sum16, 0);  chk("rst_busy16", busy16, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf8", ovf8, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed cases at WIDTH=8
        do_op("t1_05_03", 32'h05, 32'h03, 1);
        do_op("t2_ff_01", 32'hFF, 32'h01, 1);
        do_op("t2_ff_ff", 32'hFF, 32'hFF, 1);
        do_op("t2_7f_01", 32'h7F, 32'h01, 0);
        do_op("t2_80_80", 32'h80, 32'h80, 0);
`ifdef SERIAL_ADDER_OVF_EN
        do_op("t2_ovf_7f", 32'h7F, 32'h01, 0); chk("t2_ovf7f_one", ovf8, 1);
        do_op("t2_ovf_ff", 32'hFF, 32'h01, 0); chk("t2_ovfff_zero", ovf8, 0);
`endif

        // Held start with operands changing while busy
        @(negedge clk);
        a = 32'h10; b = 32'h20; start8 = 1;
        @(negedge clk);
        a = 32'h01; b = 32'h01;
        wait_done(cyc, nb);
        chk("t3_first_lat", cyc, 8);
        check_result("t3_first", 32'h10, 32'h20);
        @(negedge clk);
        chk("t3_back_busy", busy8, 1);
        chk("t3_back_done", done8, 0);
        wait_done(cyc, nb);
        chk("t3_period", cyc + 1, 9);
        check_result("t3_second", 32'h01, 32'h01);
        start8 = 0;
        @(negedge clk);

        // Reset during RUN after four processed bits
        @(negedge clk);
        a = 32'h33; b = 32'h44; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (4) @(negedge clk);
        chk("t4_busy_before", busy8, 1);
        rst = 1'b1;
        #1;
        chk("t4_busy", busy8, 0); chk("t4_done", done8, 0);
        chk("t4_sum", sum8, 0);   chk("t4_cout", cout8, 0);
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) nb++;
        end
        chk("t4_no_done", nb, 0);
        do_op("t4_after", 32'hA5, 32'h5A, 1);

        // Random operations at both widths
        for (int i = 0; i < 1000; i++)
            do_op("r8", $urandom, $urandom, (i % 50) == 0);
        sel = 1;
        do_op("d16_ffff", 32'hFFFF, 32'hFFFF, 1);
        for (int i = 0; i < 1000; i++)
            do_op("r16", $urandom, $urandom, (i % 50) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
